// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths, stream byte counts and loader FSM states
// Purpose: common definitions for prog_loader, prog_loader_if and prog_byte_packer.
// Ports: none (package). Width macros ADDR_LEN / INSN_LEN / DATA_LEN default to 32
// unless already defined by the project headers.
// Optional feature macro: PROG_LOADER_CKSUM_EN (trailing checksum byte).
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

package prog_loader_pkg;

  localparam int PROG_HDR_BYTES  = 4;
  localparam int PROG_LINE_BYTES = 16;
  localparam int LINE_W          = 4 * `INSN_LEN;
  localparam int AW              = `ADDR_LEN;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_IWR  = 3'd2,
    ST_DWR  = 3'd3,
    ST_CK   = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } prog_state_t;

  // 32-bit word k of a 128-bit line, word 0 in the least significant bits.
  function automatic logic [`DATA_LEN-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0] k);
    return line[{k, 5'b00000} +: `DATA_LEN];
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and imem/dmem load-mux output bundle
// Purpose: groups the loader's byte handshake and program-write signals.
// Signals: rx_valid/rx_data/rx_ready byte stream; prog_loading, prog_loadaddr,
// prog_loaddata, prog_imem_we, prog_dmem_we load-mux side; loaded, load_err status.
// Modports: master = the loader, slave = the byte source / load-mux consumer.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif

interface prog_loader_if;
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     prog_loading;
  logic [`ADDR_LEN-1:0]     prog_loadaddr;
  logic [4*`INSN_LEN-1:0]   prog_loaddata;
  logic                     prog_imem_we;
  logic                     prog_dmem_we;
  logic                     loaded;
  logic                     load_err;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, prog_loading, prog_loadaddr, prog_loaddata,
           prog_imem_we, prog_dmem_we, loaded, load_err
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, prog_loading, prog_loadaddr, prog_loaddata,
           prog_imem_we, prog_dmem_we, loaded, load_err
  );
endinterface

// File: rtl/prog_byte_packer.sv
// rtl/prog_byte_packer.sv - byte counter and 128-bit little-endian shift-in register
// Purpose: assembles stream bytes into a line, first byte ending up in [7:0].
// Ports: clk, reset (async, active-high); clear (zero the byte counter);
// shift (accept byte_data); line (assembled line, including a byte being shifted
// this cycle); count (bytes collected in the current group); full (16th byte shifting).
module prog_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        byte_data,
  output logic [LINE_W-1:0] line,
  output logic [3:0]        count,
  output logic              full
);

  logic [LINE_W-1:0] sreg;

  // Bytes enter at the top and move down, so after 16 shifts byte 0 sits in [7:0].
  // Exposing the in-flight value lets the FSM act on the completed line in the
  // same cycle the last byte is accepted.
  assign line = shift ? {byte_data, sreg[LINE_W-1:8]} : sreg;
  assign full = shift && (count == 4'(PROG_LINE_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      count <= '0;
    end else begin
      if (shift)
        sreg <= line;
      if (clear)
        count <= '0;
      else if (shift)
        count <= count + 4'd1;   // 4-bit counter wraps after the 16th byte
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing imem lines and dmem words
// Purpose: parses a 4-byte little-endian line count N followed by N 16-byte lines,
// writes each line to imem (one 128-bit write) then to dmem (four 32-bit writes),
// and holds the core in reset until the image is complete.
// Ports: clk; reset (async, active-high); bus (prog_loader_if.master): byte stream
// in, registered load-mux outputs and sticky loaded/load_err status out.
// Parameter: MAX_LINES - largest accepted N.
// Optional feature macro: PROG_LOADER_CKSUM_EN - one trailing byte must equal the
// mod-256 sum of all data bytes, otherwise the load ends in the error state.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_LINES = 512
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.master bus
);

`ifdef PROG_LOADER_CKSUM_EN
  localparam prog_state_t FINAL_ST = ST_CK;
`else
  localparam prog_state_t FINAL_ST = ST_DONE;
`endif

  prog_state_t state, nxt_state;

  logic [31:0]       n_q, n_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [1:0]        k_q, k_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              rdy_q, rdy_d;
  logic              loading_q, loading_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              imem_q, imem_d;
  logic              dmem_q, dmem_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              pk_shift;
  logic              pk_clear;
  logic [LINE_W-1:0] pk_line;
  logic [3:0]        pk_count;
  logic              pk_full;
  logic              hdr_last;
  logic [31:0]       hdr_n;

  // rx_ready is a register that is high exactly in the receiving states, so a
  // transfer can only happen while the FSM is listening.
  assign xfer     = bus.rx_valid && rdy_q;
  assign pk_shift = xfer && ((state == ST_HDR) || (state == ST_DATA));
  assign hdr_last = xfer && (state == ST_HDR) && (pk_count == 4'(PROG_HDR_BYTES - 1));
  assign pk_clear = hdr_last;     // data bytes must start counting from zero
  assign hdr_n    = pk_line[LINE_W-1 -: 32];

  prog_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift     (pk_shift),
    .byte_data (bus.rx_data),
    .line      (pk_line),
    .count     (pk_count),
    .full      (pk_full)
  );

  // Byte address of word k of line c; lines are 16 bytes apart.
  function automatic logic [AW-1:0] line_addr(input logic [8:0] c, input logic [1:0] k);
    return AW'({c, k, 2'b00});
  endfunction

  always_comb begin
    nxt_state = state;
    n_d       = n_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d     = sum_q;
`endif
    imem_d    = 1'b0;
    dmem_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    unique case (state)
      ST_HDR: begin
        if (hdr_last) begin
          n_d = hdr_n;
          if (hdr_n == 32'd0)
            nxt_state = FINAL_ST;
          else if (hdr_n > 32'(MAX_LINES))
            nxt_state = ST_ERR;
          else
            nxt_state = ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
`ifdef PROG_LOADER_CKSUM_EN
          sum_d = sum_q + bus.rx_data;
`endif
          if (pk_full) begin
            nxt_state = ST_IWR;
            imem_d    = 1'b1;
            addr_d    = line_addr(cnt_q[8:0], 2'd0);
            data_d    = pk_line;
          end
        end
      end

      // Outputs are registered, so each state prepares the write shown in the next one.
      ST_IWR: begin
        nxt_state = ST_DWR;
        k_d       = 2'd0;
        dmem_d    = 1'b1;
        addr_d    = line_addr(cnt_q[8:0], 2'd0);
        data_d    = {line_word(pk_line, 2'd0), {(LINE_W - `DATA_LEN){1'b0}}};
      end

      ST_DWR: begin
        if (k_q != 2'd3) begin
          k_d    = k_q + 2'd1;
          dmem_d = 1'b1;
          addr_d = line_addr(cnt_q[8:0], k_d);
          data_d = {line_word(pk_line, k_d), {(LINE_W - `DATA_LEN){1'b0}}};
        end else begin
          cnt_d = cnt_q + 10'd1;
          if ({22'd0, cnt_d} == n_q)
            nxt_state = FINAL_ST;
          else
            nxt_state = ST_DATA;
        end
      end

`ifdef PROG_LOADER_CKSUM_EN
      ST_CK: begin
        if (xfer)
          nxt_state = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
      end
`endif

      ST_DONE: nxt_state = ST_DONE;
      ST_ERR:  nxt_state = ST_ERR;
      default: nxt_state = ST_ERR;
    endcase

    rdy_d     = (nxt_state == ST_HDR) || (nxt_state == ST_DATA) || (nxt_state == ST_CK);
    loading_d = (nxt_state != ST_DONE);
    loaded_d  = (nxt_state == ST_DONE);
    err_d     = (nxt_state == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HDR;
      n_q       <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q     <= '0;
`endif
      rdy_q     <= 1'b0;
      loading_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      imem_q    <= 1'b0;
      dmem_q    <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= nxt_state;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q     <= sum_d;
`endif
      rdy_q     <= rdy_d;
      loading_q <= loading_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      imem_q    <= imem_d;
      dmem_q    <= dmem_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_ready      = rdy_q;
  assign bus.prog_loading  = loading_q;
  assign bus.prog_loadaddr = addr_q;
  assign bus.prog_loaddata = data_q;
  assign bus.prog_imem_we  = imem_q;
  assign bus.prog_dmem_we  = dmem_q;
  assign bus.loaded        = loaded_q;
  assign bus.load_err      = err_q;

endmodule
